// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - shared D-cache constants and flush FSM state type
package std_cache_pkg;

  // Default geometry shared by the tag array, write-back unit and flush unit
  localparam int unsigned DCACHE_NUM_SETS  = 256;
  localparam int unsigned DCACHE_NUM_WAYS  = 8;
  localparam int unsigned DCACHE_TAG_WIDTH = 44;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_REQ  = 4'd1,
    RD_WAIT = 4'd2,
    SCAN    = 4'd3,
    WB_REQ  = 4'd4,
    WB_WAIT = 4'd5,
    META_WR = 4'd6,
    ACK     = 4'd7,
    DROP    = 4'd8
  } flush_state_e;

endpackage

// File: rtl/lzc.sv
// rtl/lzc.sv - leading/trailing zero counter (MODE 0 = trailing zeros)
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Priority scan; later loop iterations win, so the scan order picks the
  // lowest set bit in trailing mode and the highest set bit in leading mode
  always_comb begin
    cnt_o = '0;
    if (MODE == 1'b0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/dcache_flush_unit.sv
// rtl/dcache_flush_unit.sv - D-cache flush walker; DCACHE_FLUSH_INVAL_EN also invalidates lines
module dcache_flush_unit
  import std_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS  = DCACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS  = DCACHE_NUM_WAYS,
  parameter int unsigned TAG_WIDTH = DCACHE_TAG_WIDTH,
  localparam int unsigned SET_W    = $clog2(NUM_SETS),
  localparam int unsigned WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  output logic                          flush_ack_o,
  output logic                          busy_o,
  output logic                          tag_req_o,
  input  logic                          tag_gnt_i,
  output logic [SET_W-1:0]              tag_set_o,
  input  logic                          tag_rvalid_i,
  input  logic [NUM_WAYS-1:0]           tag_valid_i,
  input  logic [NUM_WAYS-1:0]           tag_dirty_i,
  input  logic [NUM_WAYS*TAG_WIDTH-1:0] tag_i,
  output logic                          wb_req_o,
  input  logic                          wb_gnt_i,
  output logic [SET_W-1:0]              wb_set_o,
  output logic [WAY_W-1:0]              wb_way_o,
  output logic [TAG_WIDTH-1:0]          wb_tag_o,
  input  logic                          wb_done_i,
  output logic                          meta_we_o,
  input  logic                          meta_gnt_i,
  output logic [SET_W-1:0]              meta_set_o,
  output logic [NUM_WAYS-1:0]           meta_valid_o,
  output logic [NUM_WAYS-1:0]           meta_dirty_o
);

  flush_state_e                  r_state, w_next_state;
  logic [SET_W-1:0]              r_set_cnt;
  logic [NUM_WAYS-1:0]           r_pend;
  logic [NUM_WAYS-1:0]           r_valid_q;
  logic [NUM_WAYS*TAG_WIDTH-1:0] r_tags_q;
  logic [WAY_W-1:0]              r_way_q;
  logic [WAY_W-1:0]              w_lzc_cnt;
  logic                          w_pend_empty;
  logic                          w_last_set;
  logic [NUM_WAYS-1:0]           w_meta_valid;

  assign w_last_set = (r_set_cnt == SET_W'(NUM_SETS - 1));

`ifdef DCACHE_FLUSH_INVAL_EN
  assign w_meta_valid = '0;
`else
  assign w_meta_valid = r_valid_q;
`endif

  // Lowest pending way is written back first
  lzc #(
    .WIDTH    (NUM_WAYS),
    .MODE     (1'b0),
    .CNT_WIDTH(WAY_W)
  ) u_way_lzc (
    .in_i   (r_pend),
    .cnt_o  (w_lzc_cnt),
    .empty_o(w_pend_empty)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Walk bookkeeping: set counter, latched set contents, selected way
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_set_cnt <= '0;
      r_pend    <= '0;
      r_valid_q <= '0;
      r_tags_q  <= '0;
      r_way_q   <= '0;
    end else begin
      case (r_state)
        IDLE:    if (flush_i) r_set_cnt <= '0;
        RD_WAIT: if (tag_rvalid_i) begin
          r_pend    <= tag_valid_i & tag_dirty_i;
          r_valid_q <= tag_valid_i;
          r_tags_q  <= tag_i;
        end
        SCAN:    if (!w_pend_empty) r_way_q <= w_lzc_cnt;
        WB_WAIT: if (wb_done_i) r_pend[r_way_q] <= 1'b0;
        META_WR: if (meta_gnt_i && !w_last_set) r_set_cnt <= r_set_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic; flush_i is only looked at in IDLE and DROP
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (flush_i)      w_next_state = RD_REQ;
      RD_REQ:  if (tag_gnt_i)    w_next_state = RD_WAIT;
      RD_WAIT: if (tag_rvalid_i) w_next_state = SCAN;
      SCAN:    w_next_state = w_pend_empty ? META_WR : WB_REQ;
      WB_REQ:  if (wb_gnt_i)     w_next_state = WB_WAIT;
      WB_WAIT: if (wb_done_i)    w_next_state = SCAN;
      META_WR: if (meta_gnt_i)   w_next_state = w_last_set ? ACK : RD_REQ;
      ACK:     w_next_state = DROP;
      DROP:    if (!flush_i)     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are zero outside the state that owns them
  always_comb begin
    flush_ack_o  = 1'b0;
    busy_o       = (r_state != IDLE);
    tag_req_o    = 1'b0;
    tag_set_o    = '0;
    wb_req_o     = 1'b0;
    wb_set_o     = '0;
    wb_way_o     = '0;
    wb_tag_o     = '0;
    meta_we_o    = 1'b0;
    meta_set_o   = '0;
    meta_valid_o = '0;
    meta_dirty_o = '0;
    case (r_state)
      RD_REQ: begin
        tag_req_o = 1'b1;
        tag_set_o = r_set_cnt;
      end
      WB_REQ: begin
        wb_req_o = 1'b1;
        wb_set_o = r_set_cnt;
        wb_way_o = r_way_q;
        wb_tag_o = r_tags_q[int'(r_way_q)*TAG_WIDTH +: TAG_WIDTH];
      end
      META_WR: begin
        meta_we_o    = 1'b1;
        meta_set_o   = r_set_cnt;
        meta_valid_o = w_meta_valid;
      end
      ACK:     flush_ack_o = 1'b1;
      default: ;
    endcase
  end

endmodule
